// File: rtl/serial_frame_capture.sv
// Serial-to-parallel frame capture with a valid/ready holding register.
// Shifts in WIDTH bits while en is high and returns a done pulse upstream.
// Reports mid-frame en drops as abort and dropped frames as sticky overrun.
module serial_frame_capture #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0,
  localparam int unsigned CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             en,
  input  logic             data_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             done,
  output logic             abort,
  output logic             overrun,
  output logic [CW-1:0]    bit_cnt
);

  // Reject frame widths the counter and bit-placement logic cannot support.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("serial_frame_capture: WIDTH must be in the range 2..32");
  end

  localparam logic [WIDTH-1:0] LSB_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_ONE  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             valid_nxt, done_nxt, abort_nxt, ovr_nxt;
  logic             complete;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] captured;

  // Next-state, shift-register and holding-register decisions.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    dout_nxt  = data_out;
    valid_nxt = data_valid;
    done_nxt  = 1'b0;
    abort_nxt = 1'b0;
    ovr_nxt   = overrun & ~clr_ovr;
    complete  = 1'b0;

    // bit_cnt is always 0 in IDLE, so the same mask serves the first bit.
    bit_mask = MSB_FIRST ? (MSB_ONE >> bit_cnt) : (LSB_ONE << bit_cnt);
    captured = ((state == SHIFT) ? shreg : '0) | (ser_in ? bit_mask : '0);

    case (state)
      IDLE: begin
        if (en) begin
          shreg_nxt = captured;
          cnt_nxt   = CW'(1);
          state_nxt = SHIFT;
        end else begin
          cnt_nxt = '0;
        end
      end
      SHIFT: begin
        if (!en) begin
          shreg_nxt = '0;
          cnt_nxt   = '0;
          abort_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (bit_cnt == LAST_BIT) begin
          complete  = 1'b1;
          shreg_nxt = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          shreg_nxt = captured;
          cnt_nxt   = bit_cnt + CW'(1);
        end
      end
      default: begin
        shreg_nxt = '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase

    if (data_valid && data_ready) begin
      valid_nxt = 1'b0;
    end

    // A completed frame loads only if the holding register is free this edge.
    if (complete) begin
      done_nxt = 1'b1;
      if (!data_valid || data_ready) begin
        dout_nxt  = captured;
        valid_nxt = 1'b1;
      end else begin
        ovr_nxt = 1'b1;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      done       <= 1'b0;
      abort      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_cnt    <= cnt_nxt;
      data_out   <= dout_nxt;
      data_valid <= valid_nxt;
      done       <= done_nxt;
      abort      <= abort_nxt;
      overrun    <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_serial_frame_capture.sv
// Directed bench for serial_frame_capture: an LSB-first and an MSB-first
// instance share all inputs; expected outputs come from a hand-built table.
module tb_serial_frame_capture;

  logic       clk = 1'b0;
  logic       rst_n, ser_in, en, data_ready, clr_ovr;
  logic [7:0] data_out, data_out_m;
  logic       data_valid, done, abort, overrun;
  logic       data_valid_m, done_m, abort_m, overrun_m;
  logic [3:0] bit_cnt, bit_cnt_m;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_frame_capture #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .en(en),
    .data_ready(data_ready), .clr_ovr(clr_ovr),
    .data_out(data_out), .data_valid(data_valid), .done(done),
    .abort(abort), .overrun(overrun), .bit_cnt(bit_cnt)
  );

  serial_frame_capture #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .en(en),
    .data_ready(data_ready), .clr_ovr(clr_ovr),
    .data_out(data_out_m), .data_valid(data_valid_m), .done(done_m),
    .abort(abort_m), .overrun(overrun_m), .bit_cnt(bit_cnt_m)
  );

  typedef struct {
    logic       rst_n, en, ser, rdy, clr;
    logic [7:0] dout, dm;
    logic       valid, done, abort, ovr;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[$];

  // Append one cycle: inputs applied before an edge, outputs expected after it.
  task automatic v(input logic r, input logic e, input logic s, input logic rdy,
                   input logic clr, input logic [7:0] dout, input logic [7:0] dm,
                   input logic valid, input logic dn, input logic ab,
                   input logic ovr, input logic [3:0] cnt);
    vec_t t;
    t.rst_n = r; t.en = e; t.ser = s; t.rdy = rdy; t.clr = clr;
    t.dout = dout; t.dm = dm; t.valid = valid; t.done = dn;
    t.abort = ab; t.ovr = ovr; t.cnt = cnt;
    tbl.push_back(t);
  endtask

  // Mid-frame bits first..last of b (LSB first); outputs hold, count advances.
  task automatic mid(input logic [7:0] b, input int first, input int last,
                     input logic rdy, input logic [7:0] dout, input logic [7:0] dm,
                     input logic valid, input logic ovr);
    for (int k = first; k <= last; k++)
      v(1'b1, 1'b1, b[k], rdy, 1'b0, dout, dm, valid, 1'b0, 1'b0, ovr, 4'(k + 1));
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got, exp;
    logic [7:0]  pat;
    int          done_cyc[$];

    // Reset
    v(0,0,0,0,0, 8'h00,8'h00, 0,0,0,0,4'd0);
    // Frame 1,0,1,1,0,0,1,0 -> 4D / B2
    mid(8'h4D, 0, 6, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    v(1,1,0,1,0, 8'h4D,8'hB2, 1,1,0,0,4'd0);
    // Abort after 5 bits with holding register full
    mid(8'h1F, 0, 4, 1'b0, 8'h4D, 8'hB2, 1'b1, 1'b0);
    v(1,0,0,0,0, 8'h4D,8'hB2, 1,0,1,0,4'd0);
    v(1,0,0,0,0, 8'h4D,8'hB2, 1,0,0,0,4'd0);
    v(1,0,0,1,0, 8'h4D,8'hB2, 0,0,0,0,4'd0);
    // Clean frame after abort: 01 / 80
    mid(8'h01, 0, 6, 1'b0, 8'h4D, 8'hB2, 1'b0, 1'b0);
    v(1,1,0,0,0, 8'h01,8'h80, 1,1,0,0,4'd0);
    v(1,0,0,1,0, 8'h01,8'h80, 0,0,0,0,4'd0);
    // Back-to-back A5,3C with no ready: second frame overruns
    mid(8'hA5, 0, 6, 1'b0, 8'h01, 8'h80, 1'b0, 1'b0);
    v(1,1,1,0,0, 8'hA5,8'hA5, 1,1,0,0,4'd0);
    mid(8'h3C, 0, 6, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0);
    v(1,1,0,0,0, 8'hA5,8'hA5, 1,1,0,1,4'd0);
    v(1,0,0,0,1, 8'hA5,8'hA5, 1,0,0,0,4'd0);
    v(1,0,0,1,0, 8'hA5,8'hA5, 0,0,0,0,4'd0);
    // Ready on the exact completion edge of frame 2: new word loads
    mid(8'hA5, 0, 6, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0);
    v(1,1,1,0,0, 8'hA5,8'hA5, 1,1,0,0,4'd0);
    mid(8'h3C, 0, 6, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0);
    v(1,1,0,1,0, 8'h3C,8'h3C, 1,1,0,0,4'd0);
    v(1,0,0,0,0, 8'h3C,8'h3C, 1,0,0,0,4'd0);
    // Reset at bit 4 of a frame while holding register full, then FF
    mid(8'h0F, 0, 3, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b0);
    v(0,1,1,0,0, 8'h00,8'h00, 0,0,0,0,4'd0);
    mid(8'hFF, 0, 6, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    v(1,1,1,0,0, 8'hFF,8'hFF, 1,1,0,0,4'd0);
    // Overrun and clr_ovr on the same edge: overrun wins
    mid(8'h00, 0, 6, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
    v(1,1,0,0,1, 8'hFF,8'hFF, 1,1,0,1,4'd0);
    v(1,0,0,0,1, 8'hFF,8'hFF, 1,0,0,0,4'd0);
    v(1,0,0,1,0, 8'hFF,8'hFF, 0,0,0,0,4'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst_n; en = tbl[i].en; ser_in = tbl[i].ser;
      data_ready = tbl[i].rdy; clr_ovr = tbl[i].clr;
      @(posedge clk); #1;
      got = {data_out, data_out_m, data_valid, done, abort, overrun, bit_cnt,
             data_valid_m, done_m, abort_m, overrun_m, bit_cnt_m};
      exp = {tbl[i].dout, tbl[i].dm, tbl[i].valid, tbl[i].done, tbl[i].abort,
             tbl[i].ovr, tbl[i].cnt, tbl[i].valid, tbl[i].done, tbl[i].abort,
             tbl[i].ovr, tbl[i].cnt};
      check($sformatf("vec%0d", i), got, exp);
    end

    // Continuous en with ready high: done every 8 cycles, no gaps
    pat = 8'h6B;
    for (int c = 0; c < 24; c++) begin
      rst_n = 1'b1; en = 1'b1; data_ready = 1'b1; clr_ovr = 1'b0;
      ser_in = pat[c % 8];
      @(posedge clk); #1;
      if (done) done_cyc.push_back(c);
    end
    en = 1'b0; data_ready = 1'b0;
    check("stream_done_count", 32'(done_cyc.size()), 32'd3);
    if (done_cyc.size() == 3) begin
      check("stream_done_first", 32'(done_cyc[0]), 32'd7);
      check("stream_done_gap1", 32'(done_cyc[1] - done_cyc[0]), 32'd8);
      check("stream_done_gap2", 32'(done_cyc[2] - done_cyc[1]), 32'd8);
    end
    check("stream_data", {16'h0, data_out, data_out_m}, {16'h0, 8'h6B, 8'hD6});
    check("stream_flags", {28'h0, data_valid, overrun, abort, bit_cnt == 4'd0},
          {28'h0, 1'b1, 1'b0, 1'b0, 1'b1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
